// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single VGA plot port between the pixel
// generators (floor, tree, man drawer/eraser, gameover). Grants are round-robin
// and burst-locked: the owner keeps the port until it signals done, drops its
// request, or overstays TIMEOUT cycles.
//
// Handshake: req[i] is a level held for the whole burst. gnt[i] is the
// registered one-hot grant. While gnt[i] is high, a pixel is accepted on every
// cycle with valid_in[i]=1 (no backpressure) and appears on vga_* one cycle
// later. done[i] is a one-cycle pulse that ends the burst; a pixel that is
// valid in the same cycle as done is still plotted. Non-owner valid/done are
// ignored.
module vga_plot_arbiter #(
  parameter int N_REQ   = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3,
  parameter int TIMEOUT = 19200,
  parameter int TO_W    = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       done,
  input  logic [N_REQ-1:0]       valid_in,
  input  logic [N_REQ*X_W-1:0]   x_in,
  input  logic [N_REQ*Y_W-1:0]   y_in,
  input  logic [N_REQ*C_W-1:0]   colour_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [1:0]             state_dbg
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_OWN     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [TO_W-1:0] to_cnt;

  logic            found;
  logic [PW-1:0]   win;
  int              idx;
  logic [PW-1:0]   owner_next;
  logic            owner_exit;
  logic            timeout_hit;
  logic [X_W-1:0]  own_x;
  logic [Y_W-1:0]  own_y;
  logic [C_W-1:0]  own_c;

  // Round-robin search: first set req bit starting at ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Owner-side decode: next RR start, burst end conditions and pixel slice.
  always_comb begin
    owner_next  = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
    owner_exit  = done[owner] | ~req[owner];
    timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
    own_x       = x_in[int'(owner)*X_W +: X_W];
    own_y       = y_in[int'(owner)*Y_W +: Y_W];
    own_c       = colour_in[int'(owner)*C_W +: C_W];
  end

  // Arbitration FSM plus registered plot port; reset aborts any burst at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      owner       <= '0;
      to_cnt      <= '0;
      gnt         <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          vga_plot <= 1'b0;
          to_cnt   <= '0;
          if (found) begin
            gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            owner <= win;
            state <= S_OWN;
          end
        end
        S_OWN: begin
          // The owner's pixel of this cycle is plotted even on its last cycle.
          vga_plot <= valid_in[owner];
          if (valid_in[owner]) begin
            vga_x      <= own_x;
            vga_y      <= own_y;
            vga_colour <= own_c;
          end
          to_cnt <= to_cnt + TO_W'(1);
          if (owner_exit || timeout_hit) begin
            state <= S_RELEASE;
            gnt   <= '0;
            ptr   <= owner_next;
            // A clean done on the last allowed cycle is not a timeout.
            if (!owner_exit) timeout_err <= 1'b1;
          end
        end
        S_RELEASE: begin
          // One turnaround cycle with no grant and no plot.
          gnt      <= '0;
          vga_plot <= 1'b0;
          to_cnt   <= '0;
          state    <= S_IDLE;
        end
        default: begin
          gnt      <= '0;
          vga_plot <= 1'b0;
          to_cnt   <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == S_OWN) || (state == S_RELEASE);
  assign state_dbg = state;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: expected pixels are queued when an
// owner drives them and popped when vga_plot fires.
module tb_vga_plot_arbiter;

  localparam int N   = 4;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int CW  = 3;
  localparam int PXW = XW + YW + CW;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, done, valid_in;
  logic [N*XW-1:0] x_in;
  logic [N*YW-1:0] y_in;
  logic [N*CW-1:0] colour_in;
  logic [N-1:0]    gnt;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot, busy, timeout_err;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [PXW-1:0] exp_q[$];

  vga_plot_arbiter #(
    .N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .TIMEOUT(16), .TO_W(5)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .valid_in(valid_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .gnt(gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_drive();
    valid_in = '0;
    done     = '0;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c, input bit push);
    valid_in[i]           = 1'b1;
    x_in[i*XW +: XW]      = XW'(x);
    y_in[i*YW +: YW]      = YW'(y);
    colour_in[i*CW +: CW] = CW'(c);
    if (push) exp_q.push_back({XW'(x), YW'(y), CW'(c)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_drive();
    req = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int gap);
    gap = 0;
    while (gnt == '0 && gap < 20) begin
      step();
      gap++;
    end
    check("grant_within_bound", 32'(gnt != '0), 1);
  endtask

  // Scoreboard: every plot must match the oldest queued pixel; grant stays one-hot.
  always @(negedge clk) begin
    if (!reset) begin
      check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
      if (vga_plot) begin
        if (exp_q.size() == 0) begin
          check("unexpected_plot", {vga_x, vga_y, vga_colour}, 0);
        end else begin
          check("plot_pixel", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int hold;
    int own;
    req = '0; done = '0; valid_in = '0;
    x_in = '0; y_in = '0; colour_in = '0;

    // Test 1: reset state, single-owner burst of three pixels
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_state", state_dbg, 0);
    check("rst_x", vga_x, 0);
    req = 4'b0001;
    step();
    check("t1_gnt", gnt, 4'b0001);
    set_pix(0, 10, 20, 3, 1'b1); step();
    set_pix(0, 11, 20, 3, 1'b1); step();
    set_pix(0, 12, 20, 3, 1'b1); step();
    valid_in = '0; done[0] = 1'b1; step();
    done = '0; req = '0;
    check("t1_release_gnt", gnt, 0);
    check("t1_release_busy", busy, 1);
    step();
    check("t1_idle_busy", busy, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // Test 2: all requesting, round-robin order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      own = n % 4;
      wait_grant(gap);
      if (n > 0) check("t2_gap", 32'(gap >= 1 && gap <= 2), 1);
      check("t2_order", gnt, 32'(1) << own);
      set_pix(own, 50 + n, 60 + own, n % 8, 1'b1); step();
      set_pix(own, 70 + n, 61, (n + 1) % 8, 1'b1); step();
      valid_in = '0; done[own] = 1'b1; step();
      done = '0;
      check("t2_release_gnt", gnt, 0);
    end
    req = '0;
    step(); step();
    check("t2_q_empty", exp_q.size(), 0);

    // Test 3: non-owner pixels and done pulses are ignored
    do_reset();
    req = 4'b0100;
    step();
    check("t3_gnt", gnt, 4'b0100);
    set_pix(1, 99, 5, 1, 1'b0);
    set_pix(2, 40, 41, 2, 1'b1);
    step();
    valid_in = '0;
    set_pix(1, 99, 5, 1, 1'b0);
    step();
    valid_in = '0; done[1] = 1'b1; step();
    done = '0;
    check("t3_foreign_done", gnt, 4'b0100);
    check("t3_owner_x", vga_x, 40);
    done[2] = 1'b1; step();
    done = '0; req = '0;
    check("t3_release_gnt", gnt, 0);
    step(); step();

    // Test 4: timeout revocation after 16 cycles, sticky error, RR continues at 1
    do_reset();
    req = 4'b0001;
    step();
    check("t4_gnt", gnt, 4'b0001);
    hold = 1;
    while (gnt == 4'b0001 && hold < 40) begin
      step();
      if (gnt == 4'b0001) hold++;
    end
    check("t4_hold_cycles", hold, 16);
    check("t4_terr_set", timeout_err, 1);
    req = 4'b0011;
    wait_grant(gap);
    check("t4_next_owner", gnt, 4'b0010);
    check("t4_terr_sticky", timeout_err, 1);

    // Test 5: reset mid-burst aborts with no plot; pointer back to 0
    set_pix(1, 7, 7, 7, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_drive();
    check("t5_gnt", gnt, 0);
    check("t5_plot", vga_plot, 0);
    check("t5_busy", busy, 0);
    check("t5_terr", timeout_err, 0);
    check("t5_state", state_dbg, 0);
    req = 4'b1111;
    step();
    check("t5_first_gnt", gnt, 4'b0001);

    // Test 6: pixel valid together with done is plotted during RELEASE
    set_pix(0, 120, 100, 5, 1'b1);
    done[0] = 1'b1;
    step();
    clear_drive();
    req = '0;
    check("t6_gnt", gnt, 0);
    check("t6_plot", vga_plot, 1);
    check("t6_x", vga_x, 120);
    check("t6_state", state_dbg, 2);
    step();
    check("t6_plot_after", vga_plot, 0);
    check("t6_state_idle", state_dbg, 0);
    step();

    check("final_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
